// File: rtl/gestor_solicitudes.sv
// Request manager: debounces floor call buttons, latches pending requests and picks a SCAN target floor.
// Latency: a button registers ESTABLE edges after it goes high; destino/direccion follow one edge after pendientes.
// Backpressure: none; en=0 freezes every register, and the controller samples destino continuously.
module gestor_solicitudes #(
  parameter int N_PISOS    = 4,
  parameter int ANCHO_PISO = 2,
  parameter int ESTABLE    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_PISOS-1:0]    boton_pres,
  input  logic [ANCHO_PISO-1:0] piso,
  input  logic [1:0]            accion,
  input  logic                  puertas,
  output logic [N_PISOS-1:0]    pendientes,
  output logic [ANCHO_PISO-1:0] destino,
  output logic                  destino_valido,
  output logic [1:0]            direccion
);

  // State encodings double as the direccion encoding.
  typedef enum logic [1:0] {
    REPOSO = 2'b00,
    SUBIR  = 2'b01,
    BAJAR  = 2'b10
  } estado_t;

  localparam logic [3:0] ESTABLE_C = 4'(ESTABLE);

  estado_t                   estado, estado_nxt;
  logic [N_PISOS-1:0][3:0]   cnt, cnt_nxt;
  logic [N_PISOS-1:0]        armado, armado_nxt;
  logic [N_PISOS-1:0]        nuevo, borrar, pend_nxt;
  logic [N_PISOS-1:0]        arriba, abajo;
  logic                      aqui, piso_ok;
  logic [ANCHO_PISO-1:0]     sel_sub, sel_baj, destino_nxt;

  // The controller action is informational only.
  logic unused_accion;
  assign unused_accion = ^accion;

  assign direccion = estado;

  // Per-button debounce: count while held and armed, fire once on reaching ESTABLE, re-arm on release.
  always_comb begin
    cnt_nxt    = cnt;
    armado_nxt = armado;
    nuevo      = '0;
    for (int i = 0; i < N_PISOS; i++) begin
      if (!boton_pres[i]) begin
        cnt_nxt[i]    = '0;
        armado_nxt[i] = 1'b1;
      end else if (armado[i]) begin
        if (cnt[i] == ESTABLE_C - 4'd1) begin
          cnt_nxt[i]    = ESTABLE_C;
          nuevo[i]      = 1'b1;
          armado_nxt[i] = 1'b0;
        end else begin
          cnt_nxt[i] = cnt[i] + 4'd1;
        end
      end
    end
  end

  // Request latch: doors open at a legal floor clears that bit; clearing beats a simultaneous set.
  always_comb begin
    piso_ok = int'(piso) < N_PISOS;
    borrar  = '0;
    for (int i = 0; i < N_PISOS; i++) begin
      borrar[i] = puertas && piso_ok && (int'(piso) == i);
    end
    pend_nxt = (pendientes | nuevo) & ~borrar;
  end

  // Classify registered requests relative to the car and find the nearest one in each direction.
  always_comb begin
    arriba  = '0;
    abajo   = '0;
    aqui    = 1'b0;
    sel_sub = '0;
    sel_baj = '0;
    for (int i = 0; i < N_PISOS; i++) begin
      arriba[i] = pendientes[i] && (i > int'(piso));
      abajo[i]  = pendientes[i] && (i < int'(piso));
      if (pendientes[i] && (i == int'(piso))) aqui = 1'b1;
    end
    // Lowest pending index at or above the car: scan downward so the last hit wins.
    for (int i = N_PISOS - 1; i >= 0; i--) begin
      if (pendientes[i] && (i >= int'(piso))) sel_sub = ANCHO_PISO'(i);
    end
    // Highest pending index at or below the car: scan upward so the last hit wins.
    for (int i = 0; i < N_PISOS; i++) begin
      if (pendientes[i] && (i <= int'(piso))) sel_baj = ANCHO_PISO'(i);
    end
  end

  // SCAN next-state and target: keep sweeping while work remains ahead, otherwise turn or rest.
  always_comb begin
    estado_nxt  = estado;
    destino_nxt = destino;
    if (piso_ok) begin
      unique case (estado)
        REPOSO: begin
          if (aqui) begin
            destino_nxt = piso;
          end else if (|arriba) begin
            estado_nxt  = SUBIR;
            destino_nxt = sel_sub;
          end else if (|abajo) begin
            estado_nxt  = BAJAR;
            destino_nxt = sel_baj;
          end
        end
        SUBIR: begin
          if (aqui || (|arriba)) begin
            destino_nxt = sel_sub;
          end else if (|abajo) begin
            estado_nxt  = BAJAR;
            destino_nxt = sel_baj;
          end else begin
            estado_nxt = REPOSO;
          end
        end
        BAJAR: begin
          if (aqui || (|abajo)) begin
            destino_nxt = sel_baj;
          end else if (|arriba) begin
            estado_nxt  = SUBIR;
            destino_nxt = sel_sub;
          end else begin
            estado_nxt = REPOSO;
          end
        end
        default: estado_nxt = REPOSO;
      endcase
    end
  end

  // State register; reset wins over en, and en=0 holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      armado         <= '1;
      pendientes     <= '0;
      destino        <= '0;
      destino_valido <= 1'b0;
      estado         <= REPOSO;
    end else if (en) begin
      cnt            <= cnt_nxt;
      armado         <= armado_nxt;
      pendientes     <= pend_nxt;
      destino        <= destino_nxt;
      destino_valido <= |pendientes;
      estado         <= estado_nxt;
    end
  end

endmodule

// File: tb/tb_gestor_solicitudes.sv
// Bench for gestor_solicitudes: scenario tasks push expected outputs to a scoreboard and compare after the edge.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_gestor_solicitudes;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] boton_pres;
  logic [1:0] piso;
  logic [1:0] accion;
  logic       puertas;
  logic [3:0] pendientes;
  logic [1:0] destino;
  logic       destino_valido;
  logic [1:0] direccion;

  int checks   = 0;
  int failures = 0;

  // Expected output vector {pendientes, destino, destino_valido, direccion} with a care mask.
  typedef struct {
    string      nm;
    logic [8:0] val;
    logic [8:0] msk;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  localparam logic [8:0] ALL  = 9'h1FF;
  localparam logic [8:0] PEND = 9'h1E0;

  gestor_solicitudes #(.N_PISOS(4), .ANCHO_PISO(2), .ESTABLE(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .boton_pres     (boton_pres),
    .piso           (piso),
    .accion         (accion),
    .puertas        (puertas),
    .pendientes     (pendientes),
    .destino        (destino),
    .destino_valido (destino_valido),
    .direccion      (direccion)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {pendientes, destino, destino_valido, direccion};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; boton_pres = '0; piso = '0; accion = 2'b00; puertas = 1'b0;
    tick(2);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      sb.push_back('{"reset_idle", 9'b0000_00_0_00, ALL});
      tick(1);
      e = sb.pop_front(); checks++;
      if ((obs() & e.msk) !== (e.val & e.msk)) begin
        failures++; $display("FAIL %s cycle=%0d observed=%b expected=%b", e.nm, c, obs(), e.val);
      end
    end
  endtask

  task automatic test_debounce();
    piso = 2'd0; accion = 2'b01;
    boton_pres = 4'b0100; tick(2);
    boton_pres = 4'b0000;
    sb.push_back('{"short_pulse", 9'b0000_00_0_00, ALL});
    tick(1);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
    boton_pres = 4'b0100;
    sb.push_back('{"debounce_2nd_edge", 9'b0000_00_0_00, ALL});
    tick(2);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
    sb.push_back('{"debounce_3rd_edge", 9'b0100_00_0_00, ALL});
    tick(1);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
    for (int c = 0; c < 2; c++) begin
      sb.push_back('{"target_after_set", 9'b0100_10_1_01, ALL});
      tick(1);
      e = sb.pop_front(); checks++;
      if ((obs() & e.msk) !== (e.val & e.msk)) begin
        failures++; $display("FAIL %s cycle=%0d observed=%b expected=%b", e.nm, c, obs(), e.val);
      end
    end
    boton_pres = 4'b0000;
    sb.push_back('{"held_no_new", 9'b0100_10_1_01, ALL});
    tick(1);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
  endtask

  task automatic test_sweep_order();
    piso = 2'd1; boton_pres = 4'b1001;
    tick(3);
    boton_pres = 4'b0000;
    sb.push_back('{"sweep_pend_1101", 9'b1101_10_1_01, ALL});
    tick(1);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
    piso = 2'd2; puertas = 1'b1;
    sb.push_back('{"sweep_clear2", 9'b1001_10_1_01, ALL});
    tick(1);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
    puertas = 1'b0;
    sb.push_back('{"sweep_next3", 9'b1001_11_1_01, ALL});
    tick(1);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
    piso = 2'd3; puertas = 1'b1;
    sb.push_back('{"sweep_clear3", 9'b0001_11_1_01, ALL});
    tick(1);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
    puertas = 1'b0;
    sb.push_back('{"sweep_turn_down", 9'b0001_00_1_10, ALL});
    tick(1);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
  endtask

  task automatic test_set_clear_same_edge();
    piso = 2'd1; puertas = 1'b1; boton_pres = 4'b0010; accion = 2'b11;
    sb.push_back('{"clear_wins", 9'b0001_00_0_00, PEND});
    tick(3);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
    puertas = 1'b0;
    sb.push_back('{"held_no_rerequest", 9'b0001_00_0_00, PEND});
    tick(4);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
    boton_pres = 4'b0000; tick(1);
    boton_pres = 4'b0010;
    sb.push_back('{"repress_registers", 9'b0011_00_0_00, PEND});
    tick(3);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
    boton_pres = 4'b0000; accion = 2'b10;
    piso = 2'd0; puertas = 1'b1; tick(1);
    piso = 2'd1; tick(1);
    puertas = 1'b0;
    sb.push_back('{"empty_holds_dest", 9'b0000_01_0_00, ALL});
    tick(1);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
  endtask

  task automatic test_current_floor_enable();
    piso = 2'd2; accion = 2'b00; boton_pres = 4'b0100;
    tick(3);
    boton_pres = 4'b0000;
    sb.push_back('{"current_floor", 9'b0100_10_1_00, ALL});
    tick(1);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
    en = 1'b0; boton_pres = 4'b0001; piso = 2'd0;
    sb.push_back('{"enable_freeze", 9'b0100_10_1_00, ALL});
    tick(10);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
    boton_pres = 4'b0000; piso = 2'd2; en = 1'b1;
    sb.push_back('{"enable_resume", 9'b0100_10_1_00, ALL});
    tick(1);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
  endtask

  task automatic test_mid_reset();
    puertas = 1'b1; tick(1);
    puertas = 1'b0; piso = 2'd3; boton_pres = 4'b0010;
    tick(3);
    boton_pres = 4'b0000;
    sb.push_back('{"turn_down_from_rest", 9'b0010_01_1_10, ALL});
    tick(1);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
    boton_pres = 4'b1000; tick(3);
    boton_pres = 4'b0000;
    sb.push_back('{"pend_1010_down", 9'b1010_11_1_10, ALL});
    tick(1);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
    rst = 1'b1; en = 1'b0;
    sb.push_back('{"mid_reset", 9'b0000_00_0_00, ALL});
    tick(1);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
    rst = 1'b0; en = 1'b1;
    sb.push_back('{"after_reset", 9'b0000_00_0_00, ALL});
    tick(2);
    e = sb.pop_front(); checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      failures++; $display("FAIL %s observed=%b expected=%b", e.nm, obs(), e.val);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_sweep_order();
    test_set_clear_same_edge();
    test_current_floor_enable();
    test_mid_reset();
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain leftover=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gestor_solicitudes.md
Name: gestor_solicitudes

Overview:
Request manager that sits in front of maquina_estados. It debounces the four floor call buttons and latches them as pending requests. It picks the next target floor with a direction-preserving sweep (SCAN) and clears each request once the car reports that floor with doors open. Its outputs feed the controller's target input; its inputs are the controller's piso/accion/puertas outputs.

Parameters:
N_PISOS, 4, number of floors; width of boton_pres and pendientes.
ANCHO_PISO, 2, width of piso/destino; must satisfy 2**ANCHO_PISO >= N_PISOS.
ESTABLE, 3, consecutive cycles a button must stay high before it registers (1..15).

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  reset; synchronous, active-high.
en  input  1  global enable; 0 freezes all state, counters and outputs.
boton_pres  input  N_PISOS  raw call buttons; bit i = floor i requested.
piso  input  ANCHO_PISO  current floor from controller.
accion  input  2  controller action: 00 stopped, 01 up, 10 down, 11 reserved (treated as 00).
puertas  input  1  1 = doors open at floor piso.
pendientes  output  N_PISOS  latched pending requests.
destino  output  ANCHO_PISO  selected target floor.
destino_valido  output  1  1 while destino is meaningful.
direccion  output  2  sweep direction, same encoding as accion.

Behaviour:
- Reset (rst=1 at edge): pendientes=0, destino=0, destino_valido=0, direccion=00, state REPOSO, all debounce counters=0, all buttons armed. Reset overrides en.
- en=0: nothing updates. Button activity while en=0 is lost; counters hold their value.
- Debounce, per bit i, a 4-bit counter:
  - Counter increments while boton_pres[i]=1 and the bit is armed, saturating at ESTABLE.
  - On the edge where it reaches ESTABLE: set pendientes[i] and disarm the bit.
  - boton_pres[i]=0 clears the counter and re-arms. One request per press.
- Clear: pendientes[i] clears on any edge with puertas=1 and piso==i.
  - Set and clear of the same bit on the same edge: clear wins.
  - A button held through the door-open period does not re-request until it is released and pressed again.
- Sweep FSM, states REPOSO/SUBIR/BAJAR; direccion = 00/01/10 respectively. Define arriba = pending bits with index > piso, abajo = pending bits with index < piso, aqui = pendientes[piso].
  - REPOSO: aqui -> stay, destino=piso. Else arriba≠0 -> SUBIR. Else abajo≠0 -> BAJAR. Else stay.
  - SUBIR: aqui or arriba≠0 -> stay, destino = lowest pending index >= piso. Else abajo≠0 -> BAJAR. Else REPOSO.
  - BAJAR: mirror of SUBIR; destino = highest pending index <= piso. Else arriba≠0 -> SUBIR. Else REPOSO.
  - Tie REPOSO with both arriba and abajo non-zero: SUBIR.
- Timing and handshake:
  - Decisions use the registered pendientes, so a new request affects destino/direccion one edge after pendientes sets.
  - destino_valido = (pendientes≠0), registered with destino.
  - destino may change while the car moves (a nearer same-direction call); the controller samples it continuously.
  - When pendientes becomes 0: destino_valido=0, destino holds its last value.
- accion is informational only and does not affect the FSM; 11 is ignored.
- piso >= N_PISOS (illegal): no clear occurs and the FSM holds its state.
- rst asserted mid-sweep: everything returns to reset values on that edge; requests are lost.

Test Plan:
- Reset/idle: rst=1 two cycles, en=1, no buttons -> pendientes=0000, destino_valido=0, direccion=00 for 20 cycles.
- Debounce: piso=0, pulse boton_pres=0100 for 2 cycles (ESTABLE=3) -> no change; hold 5 cycles -> pendientes=0100 on the 3rd edge, next edge destino=2, destino_valido=1, direccion=01; holding longer sets nothing new.
- Sweep order: piso=1, state SUBIR, pendientes=1101 -> destino=2. Set piso=2, puertas=1 -> bit2 clears, destino=3. Piso=3 with doors open -> state BAJAR, destino=0.
- Simultaneous set/clear: piso=1, puertas=1, boton_pres[1] reaching ESTABLE on the same edge -> pendientes[1] stays 0.
- Current floor and enable: REPOSO, piso=2, press floor 2 -> destino=2, direccion=00. Drop en for 10 cycles while pressing floor 0 -> pendientes unchanged.
- Mid-operation reset: pendientes=1010, direccion=10, assert rst one cycle -> all outputs 0 on the next edge.
